stepper_move_seq: RTL and testbench

Move sequencer sitting directly upstream of the stepper coil-phase controller. Accepts a move command (step count, direction) through a start/busy/done handshake and emits one-cycle `step_tick` pulses at a trapezoidal rate profile (accelerate, cruise, decelerate). The downstream stage advances its coil pattern once per `step_tick` and uses `dir` to pick the rotation order.

---
 rtl/stepper_move_seq.sv | 167 ++++++++++++++++
 tb/tb_stepper_move_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_move_seq.sv
// Move sequencer: accepts a step-count/direction command and emits step_tick pulses on a rate profile.
// Build with STEP_RAMP_EN defined for the trapezoidal profile; undefined gives constant MIN_DIV rate.
//
// phase  | meaning
// IDLE   | no move in progress, start is sampled
// ACCEL  | period shrinks by ACC_STEP each step
// CRUISE | period held at its minimum
// DECEL  | period grows back toward START_DIV
module stepper_move_seq #(
  parameter int CNT_W     = 16,
  parameter int DIV_W     = 20,
  parameter int START_DIV = 50000,
  parameter int MIN_DIV   = 10000,
  parameter int ACC_STEP  = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir_in,
  input  logic [CNT_W-1:0] steps,
  input  logic             abort,
  output logic             step_tick,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] steps_left
);

  typedef enum logic [1:0] {
    PH_IDLE   = 2'b00,
    PH_ACCEL  = 2'b01,
    PH_CRUISE = 2'b10,
    PH_DECEL  = 2'b11
  } phase_t;

  localparam logic [DIV_W-1:0] START_V = DIV_W'(START_DIV);
  localparam logic [DIV_W-1:0] MIN_V   = DIV_W'(MIN_DIV);
  // An illegal parameter set never lets a move start.
  localparam bit CFG_OK = (START_DIV >= MIN_DIV) && (MIN_DIV >= 2) && (ACC_STEP >= 0);

`ifdef STEP_RAMP_EN
  localparam phase_t           FIRST_PH  = PH_ACCEL;
  localparam logic [DIV_W-1:0] FIRST_DIV = START_V;
`else
  localparam phase_t           FIRST_PH  = PH_CRUISE;
  localparam logic [DIV_W-1:0] FIRST_DIV = MIN_V;
`endif

  phase_t           phase_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;
  logic             tick_q;
  logic             dir_q;
  logic [CNT_W-1:0] steps_left_q;
  logic [DIV_W-1:0] cur_div_q;
  logic [DIV_W-1:0] div_cnt_q;

  logic             finish;
  logic             tick_due;
  logic [DIV_W-1:0] div_cnt_inc;
  logic [CNT_W-1:0] left_dec;

  // A move ends on abort, or the cycle after the tick that used up the last step.
  always_comb begin
    finish      = busy_q && (abort || (tick_q && (steps_left_q == '0)));
    div_cnt_inc = div_cnt_q + 1'b1;
    tick_due    = busy_q && !finish && (div_cnt_inc == cur_div_q);
    left_dec    = steps_left_q - 1'b1;
  end

`ifdef STEP_RAMP_EN
  localparam logic [DIV_W:0] ACC_X        = (DIV_W+1)'(ACC_STEP);
  localparam logic [DIV_W:0] START_X      = (DIV_W+1)'(START_DIV);
  localparam logic [DIV_W:0] FAST_FLOOR_X = (DIV_W+1)'(MIN_DIV + ACC_STEP);

  logic [CNT_W-1:0] ramp_cnt_q;
  logic [DIV_W:0]   div_sum;
  logic [DIV_W-1:0] div_slower;
  logic [DIV_W-1:0] div_faster;
  logic             ramp_down;

  // One extra bit keeps the clamp compares free of wrap-around.
  always_comb begin
    div_sum    = {1'b0, cur_div_q} + ACC_X;
    div_slower = (div_sum > START_X) ? START_V : div_sum[DIV_W-1:0];
    div_faster = ({1'b0, cur_div_q} < FAST_FLOOR_X) ? MIN_V : (cur_div_q - ACC_X[DIV_W-1:0]);
    ramp_down  = (left_dec <= ramp_cnt_q);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q      <= PH_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      tick_q       <= 1'b0;
      dir_q        <= 1'b0;
      steps_left_q <= '0;
      cur_div_q    <= START_V;
      div_cnt_q    <= '0;
`ifdef STEP_RAMP_EN
      ramp_cnt_q   <= '0;
`endif
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      if (!busy_q) begin
        if (start && CFG_OK) begin
          dir_q        <= dir_in;
          steps_left_q <= steps;
          aborted_q    <= 1'b0;
          cur_div_q    <= FIRST_DIV;
          div_cnt_q    <= DIV_W'(1);
`ifdef STEP_RAMP_EN
          ramp_cnt_q   <= '0;
`endif
          if (steps == '0) begin
            done_q <= 1'b1;
          end else begin
            busy_q  <= 1'b1;
            phase_q <= FIRST_PH;
          end
        end
      end else if (finish) begin
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
        phase_q   <= PH_IDLE;
        aborted_q <= abort;
        div_cnt_q <= '0;
      end else if (tick_due) begin
        tick_q       <= 1'b1;
        steps_left_q <= left_dec;
        div_cnt_q    <= '0;
`ifdef STEP_RAMP_EN
        if (left_dec != '0) begin
          if (ramp_down) begin
            phase_q    <= PH_DECEL;
            cur_div_q  <= div_slower;
            ramp_cnt_q <= (ramp_cnt_q == '0) ? '0 : (ramp_cnt_q - 1'b1);
          end else if (phase_q == PH_ACCEL) begin
            cur_div_q  <= div_faster;
            ramp_cnt_q <= ramp_cnt_q + 1'b1;
            if (div_faster == MIN_V) begin
              phase_q <= PH_CRUISE;
            end
          end
        end
`endif
      end else begin
        div_cnt_q <= div_cnt_inc;
      end
    end
  end

  assign step_tick  = tick_q;
  assign dir        = dir_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign phase      = phase_q;
  assign steps_left = steps_left_q;

endmodule

// File: tb/tb_stepper_move_seq.sv
// Bench for stepper_move_seq: a tick-schedule model predicts every output each cycle of a move.
// Honours STEP_RAMP_EN the same way the design does.
`timescale 1ns/1ps
module tb_stepper_move_seq;
  localparam int CNT_W     = 16;
  localparam int DIV_W     = 20;
  localparam int START_DIV = 8;
  localparam int MIN_DIV   = 4;
  localparam int ACC_STEP  = 2;
  localparam int MAXC      = 128;
`ifdef STEP_RAMP_EN
  localparam bit RAMP       = 1'b1;
  localparam int DONE_10    = 53;
  localparam int DONE_3     = 23;
  localparam int ABORT_AT   = 20;
  localparam int ABORT_LEFT = 7;
  localparam int COINC_AT   = 14;
`else
  localparam bit RAMP       = 1'b0;
  localparam int DONE_10    = 41;
  localparam int DONE_3     = 13;
  localparam int ABORT_AT   = 20;
  localparam int ABORT_LEFT = 5;
  localparam int COINC_AT   = 12;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             dir_in;
  logic [CNT_W-1:0] steps;
  logic             abort;
  logic             step_tick;
  logic             dir;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [1:0]       phase;
  logic [CNT_W-1:0] steps_left;

  stepper_move_seq #(
    .CNT_W(CNT_W), .DIV_W(DIV_W), .START_DIV(START_DIV), .MIN_DIV(MIN_DIV), .ACC_STEP(ACC_STEP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dir_in(dir_in), .steps(steps), .abort(abort),
    .step_tick(step_tick), .dir(dir), .busy(busy), .done(done), .aborted(aborted),
    .phase(phase), .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int e_tick[MAXC], e_busy[MAXC], e_phase[MAXC], e_left[MAXC];
  int e_done[MAXC], e_ab[MAXC], e_dir[MAXC];
  int exp_len = 0;
  int move_base = 0;
  bit chk_en = 1'b0;
  int tick_q[$];
  int done_rel = -1;

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic fill(input int from, input int to, input int tk, input int bz, input int ph,
                      input int lf, input int dn, input int ab, input int d);
    for (int c = from; c <= to && c < MAXC; c++) begin
      e_tick[c] = tk; e_busy[c] = bz; e_phase[c] = ph; e_left[c] = lf;
      e_done[c] = dn; e_ab[c] = ab; e_dir[c] = d;
    end
  endtask

  // Walks the move tick by tick: each tick lands 'period' cycles after the previous one.
  task automatic build(input int n, input int abort_at, input int d);
    int t, dv, rc, left, ph, nt, c, end_c, ab;
    t = 0; rc = 0; left = n; ab = 0; c = 1; end_c = 1;
    dv = RAMP ? START_DIV : MIN_DIV;
    ph = RAMP ? 1 : 2;
    if (n != 0) begin
      while (1) begin
        nt = t + dv;
        if (abort_at >= 0 && abort_at < nt) begin
          fill(c, abort_at, 0, 1, ph, left, 0, 0, d);
          end_c = abort_at + 1; ab = 1;
          break;
        end
        fill(c, nt - 1, 0, 1, ph, left, 0, 0, d);
        left = left - 1;
        if (left != 0) begin
          if (RAMP && left <= rc) begin
            ph = 3;
            dv = (dv + ACC_STEP > START_DIV) ? START_DIV : dv + ACC_STEP;
            rc = (rc > 0) ? rc - 1 : 0;
          end else if (ph == 1) begin
            dv = (dv - ACC_STEP < MIN_DIV) ? MIN_DIV : dv - ACC_STEP;
            rc = rc + 1;
            if (dv == MIN_DIV) ph = 2;
          end
        end
        fill(nt, nt, 1, 1, ph, left, 0, 0, d);
        if (abort_at == nt) begin end_c = nt + 1; ab = 1; break; end
        if (left == 0) begin end_c = nt + 1; break; end
        t = nt; c = nt + 1;
      end
    end
    fill(end_c, end_c, 0, 0, 0, left, 1, ab, d);
    exp_len = end_c + 1;
  endtask

  always @(negedge clk) begin
    int rel;
    if (chk_en) begin
      rel = cyc - move_base;
      if (rel >= 1 && rel < exp_len) begin
        check("step_tick", rel, step_tick, e_tick[rel]);
        check("busy", rel, busy, e_busy[rel]);
        check("phase", rel, phase, e_phase[rel]);
        check("steps_left", rel, steps_left, e_left[rel]);
        check("done", rel, done, e_done[rel]);
        check("aborted", rel, aborted, e_ab[rel]);
        check("dir", rel, dir, e_dir[rel]);
      end
      if (step_tick) tick_q.push_back(rel);
      if (done && done_rel < 0) done_rel = rel;
    end
  end

  // Called just after the falling edge of the accept cycle.
  task automatic begin_move(input int n, input int d, input int abort_at);
    build(n, abort_at, d);
    move_base = cyc;
    tick_q.delete();
    done_rel = -1;
    chk_en = 1'b1;
    start = 1'b1; dir_in = d[0]; steps = CNT_W'(n);
  endtask

  task automatic run_move(input int n, input int d, input int abort_at, input int ign_at);
    begin_move(n, d, abort_at);
    for (int r = 1; r < exp_len; r++) begin
      @(negedge clk); #1;
      start = (r == ign_at);
      if (r == ign_at) begin steps = CNT_W'(5); dir_in = (d == 0); end
      abort = (r == abort_at);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check("idle step_tick", i, step_tick, 0);
      check("idle busy", i, busy, 0);
      check("idle done", i, done, 0);
      #1;
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " step_tick"}, -1, step_tick, 0);
    check({tag, " dir"}, -1, dir, 0);
    check({tag, " busy"}, -1, busy, 0);
    check({tag, " done"}, -1, done, 0);
    check({tag, " aborted"}, -1, aborted, 0);
    check({tag, " phase"}, -1, phase, 0);
    check({tag, " steps_left"}, -1, steps_left, 0);
  endtask

  task automatic check_ticks(input string name, input int lit[$]);
    check({name, " count"}, -1, tick_q.size(), lit.size());
    for (int i = 0; i < lit.size() && i < tick_q.size(); i++) check(name, i, tick_q[i], lit[i]);
  endtask

  initial begin
    int lit[$];
    rst = 1'b1; start = 1'b0; dir_in = 1'b0; abort = 1'b0; steps = '0;
    repeat (3) @(negedge clk);
    check_cleared("por");
    #1 rst = 1'b0;
    idle(2);

    run_move(10, 1, -1, -1);
`ifdef STEP_RAMP_EN
    lit = '{8, 14, 18, 22, 26, 30, 34, 38, 44, 52};
`else
    lit = '{4, 8, 12, 16, 20, 24, 28, 32, 36, 40};
`endif
    check_ticks("ticks10", lit);
    check("done10 cycle", -1, done_rel, DONE_10);
    idle(2);

    run_move(3, 0, -1, 5);
`ifdef STEP_RAMP_EN
    lit = '{8, 14, 22};
`else
    lit = '{4, 8, 12};
`endif
    check_ticks("ticks3", lit);
    check("done3 cycle", -1, done_rel, DONE_3);
    idle(2);

    run_move(0, 1, -1, -1);
    check("zero ticks", -1, tick_q.size(), 0);
    check("zero done cycle", -1, done_rel, 1);
    abort = 1'b1;
    @(negedge clk);
    check("idle abort aborted", -1, aborted, 0);
    check("idle abort busy", -1, busy, 0);
    check("idle abort done", -1, done, 0);
    #1 abort = 1'b0;
    idle(1);

    run_move(10, 0, ABORT_AT, 10);
`ifdef STEP_RAMP_EN
    lit = '{8, 14, 18};
`else
    lit = '{4, 8, 12, 16, 20};
`endif
    check_ticks("ticks abort", lit);
    check("abort left", -1, steps_left, ABORT_LEFT);
    check("abort flag", -1, aborted, 1);
    run_move(2, 1, -1, -1);
    idle(2);

    run_move(10, 1, COINC_AT, -1);
    idle(2);

    begin_move(10, 1, -1);
    for (int r = 1; r < 16; r++) begin
      @(negedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #1;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check_cleared("rst mid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst hold step_tick", i, step_tick, 0);
      check("rst hold busy", i, busy, 0);
    end
    #1 rst = 1'b0;
    idle(2);

    run_move(3, 0, -1, -1);
    check("post rst done cycle", -1, done_rel, DONE_3);
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
